// File: rtl/xor_edge_qualifier.sv
// Synchronizes and deglitches the asynchronous XOR comparator output. Each
// qualified transition is reported on a valid/ready event port with its polarity
// and the cycle interval since the previous transition.
module xor_edge_qualifier #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic             level_o,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_rise,
  output logic [CNT_W-1:0] evt_interval,
  output logic             ovf_o,
  input  logic             clr_ovf
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [0:0]  ST_STABLE    = 1'b0;
  localparam logic [0:0]  ST_CANDIDATE = 1'b1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [STAB_W-1:0] STAB_TGT = STAB_W'(STABLE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [0:0]             state_q, state_d;
  logic [STAB_W-1:0]      stab_cnt_q, stab_cnt_d;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       iv_cnt_q, iv_cnt_d;
  logic                   evt_valid_q, evt_valid_d;
  logic                   evt_rise_q, evt_rise_d;
  logic [CNT_W-1:0]       evt_interval_q, evt_interval_d;
  logic                   ovf_q, ovf_d;

  logic                   s_c;
  logic [STAB_W-1:0]      stab_next_c;
  logic                   qual_c;
  logic                   load_c;
  logic                   drop_c;

  assign s_c = sync_q[SYNC_STAGES-1];

  // Next-state logic: synchronizer, stability filter, interval counter, event slot.
  always_comb begin
    sync_d         = {sync_q[SYNC_STAGES-2:0], din};
    state_d        = ST_STABLE;
    stab_cnt_d     = '0;
    level_d        = level_q;
    qual_c         = 1'b0;
    iv_cnt_d       = iv_cnt_q;
    evt_valid_d    = evt_valid_q;
    evt_rise_d     = evt_rise_q;
    evt_interval_d = evt_interval_q;
    ovf_d          = ovf_q;

    // Number of consecutive mismatch samples including the current one.
    stab_next_c = (state_q == ST_CANDIDATE) ? stab_cnt_q + STAB_W'(1) : STAB_W'(1);

    if (s_c != level_q) begin
      if (stab_next_c == STAB_TGT) begin
        level_d = s_c;
        qual_c  = 1'b1;
      end else begin
        state_d    = ST_CANDIDATE;
        stab_cnt_d = stab_next_c;
      end
    end

    if (qual_c) begin
      iv_cnt_d = CNT_W'(1);
    end else if (iv_cnt_q != CNT_MAX) begin
      iv_cnt_d = iv_cnt_q + CNT_W'(1);
    end

    // A pending event being accepted this cycle frees the slot for a new one.
    load_c = qual_c && (!evt_valid_q || evt_ready);
    drop_c = qual_c && !load_c;

    if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
    if (load_c) begin
      evt_valid_d    = 1'b1;
      evt_rise_d     = level_d;
      evt_interval_d = iv_cnt_q;
    end

    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q         <= '0;
      state_q        <= ST_STABLE;
      stab_cnt_q     <= '0;
      level_q        <= 1'b0;
      iv_cnt_q       <= '0;
      evt_valid_q    <= 1'b0;
      evt_rise_q     <= 1'b0;
      evt_interval_q <= '0;
      ovf_q          <= 1'b0;
    end else begin
      sync_q         <= sync_d;
      state_q        <= state_d;
      stab_cnt_q     <= stab_cnt_d;
      level_q        <= level_d;
      iv_cnt_q       <= iv_cnt_d;
      evt_valid_q    <= evt_valid_d;
      evt_rise_q     <= evt_rise_d;
      evt_interval_q <= evt_interval_d;
      ovf_q          <= ovf_d;
    end
  end

  assign level_o      = level_q;
  assign evt_valid    = evt_valid_q;
  assign evt_rise     = evt_rise_q;
  assign evt_interval = evt_interval_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_xor_edge_qualifier.sv
// Bench for xor_edge_qualifier: a default instance plus a CNT_W=3 instance on the
// same inputs to observe interval saturation; expected events go through a queue.
module tb_xor_edge_qualifier;

  localparam int unsigned SYNC = 2;
  localparam int unsigned STAB = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned WS   = 3;
  localparam int unsigned LAT  = SYNC + STAB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din = 1'b0;
  logic          evt_ready = 1'b0;
  logic          clr_ovf = 1'b0;
  logic          level_o, evt_valid, evt_rise, ovf_o;
  logic [W-1:0]  evt_interval;
  logic          s_level, s_valid, s_rise, s_ovf;
  logic [WS-1:0] s_interval;

  typedef struct {
    logic        rise;
    int unsigned iv;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_ref = 0;

  xor_edge_qualifier #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .level_o(level_o), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_rise(evt_rise), .evt_interval(evt_interval),
    .ovf_o(ovf_o), .clr_ovf(clr_ovf)
  );

  xor_edge_qualifier #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .CNT_W(WS)) dut_s (
    .clk(clk), .rst_n(rst_n), .din(din), .level_o(s_level), .evt_valid(s_valid),
    .evt_ready(evt_ready), .evt_rise(s_rise), .evt_interval(s_interval),
    .ovf_o(s_ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned sat(input int unsigned d, input int unsigned w);
    int unsigned m;
    m = (1 << w) - 1;
    return (d > m) ? m : d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Called right after din is driven: predicts the qualifying edge and its interval.
  task automatic expect_edge(input logic rise, input bit kept, output int f, output int unsigned iv);
    exp_t e;
    f  = cyc + LAT;
    iv = f - last_ref;
    e.rise = rise;
    e.iv   = iv;
    if (kept) exp_q.push_back(e);
    last_ref = f;
  endtask

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n_checks++;
        if ({s_valid, s_level, s_rise, s_ovf} !== {evt_valid, level_o, evt_rise, ovf_o}) begin
          n_fail++;
          $display("FAIL inst_match: small=%b default=%b, required equal",
                   {s_valid, s_level, s_rise, s_ovf}, {evt_valid, level_o, evt_rise, ovf_o});
        end
        if (evt_valid && evt_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL evt_unexpected: got rise=%0b interval=%0d at cyc %0d, required no event",
                     evt_rise, evt_interval, cyc);
          end else begin
            e = exp_q.pop_front();
            if (evt_rise !== e.rise || evt_interval !== W'(sat(e.iv, W)) ||
                s_interval !== WS'(sat(e.iv, WS))) begin
              n_fail++;
              $display("FAIL evt_payload: got rise=%0b iv=%0d iv_small=%0d, required rise=%0b iv=%0d iv_small=%0d",
                       evt_rise, evt_interval, s_interval, e.rise, sat(e.iv, W), sat(e.iv, WS));
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din = 1'b0; evt_ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    n_checks++;
    if ({level_o, evt_valid, evt_rise, evt_interval, ovf_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got lvl=%b v=%b r=%b iv=%0d ovf=%b, required all 0",
               level_o, evt_valid, evt_rise, evt_interval, ovf_o);
    end
    last_ref = cyc + 1;
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      n_checks++;
      if ({level_o, evt_valid, ovf_o, s_valid} !== 4'b0000) begin
        n_fail++;
        $display("FAIL idle_quiet: got lvl=%b v=%b ovf=%b sv=%b, required 0000",
                 level_o, evt_valid, ovf_o, s_valid);
      end
    end
  endtask

  task automatic test_single_rise();
    int f;
    int unsigned iv;
    evt_ready = 1'b1;
    din = 1'b1;
    expect_edge(1'b1, 1'b1, f, iv);
    repeat (LAT + 3) begin
      tick();
      n_checks++;
      if (level_o !== (cyc >= f) || evt_valid !== (cyc == f)) begin
        n_fail++;
        $display("FAIL rise_latency: cyc %0d got lvl=%b v=%b, required lvl=%b v=%b",
                 cyc, level_o, evt_valid, cyc >= f, cyc == f);
      end
    end
  endtask

  task automatic test_glitch_filter();
    int f;
    int f1;
    int unsigned iv;
    evt_ready = 1'b1;
    din = 1'b0;
    expect_edge(1'b0, 1'b1, f, iv);
    wait_until(f + 2);
    n_checks++;
    if (level_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_level: got %b, required 0", level_o);
    end
    din = 1'b1;
    repeat (STAB - 1) tick();
    din = 1'b0;
    repeat (12) begin
      tick();
      n_checks++;
      if (level_o !== 1'b0 || evt_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL short_pulse: cyc %0d got lvl=%b v=%b, required 0 0", cyc, level_o, evt_valid);
      end
    end
    din = 1'b1;
    expect_edge(1'b1, 1'b1, f1, iv);
    repeat (STAB) tick();
    din = 1'b0;
    expect_edge(1'b0, 1'b1, f, iv);
    while (cyc < f + 2) begin
      tick();
      n_checks++;
      if (level_o !== (cyc >= f1 && cyc < f1 + STAB)) begin
        n_fail++;
        $display("FAIL min_pulse: cyc %0d got lvl=%b, required %b", cyc, level_o,
                 cyc >= f1 && cyc < f1 + STAB);
      end
    end
  endtask

  task automatic test_overflow();
    int k, f1, f2, f3;
    int unsigned iv1, iv;
    evt_ready = 1'b0;
    k = cyc;
    din = 1'b1;
    expect_edge(1'b1, 1'b1, f1, iv1);
    wait_until(k + 4);
    din = 1'b0;
    expect_edge(1'b0, 1'b0, f2, iv);
    while (cyc < f2 + 2) begin
      tick();
      n_checks++;
      if (ovf_o !== (cyc >= f2)) begin
        n_fail++;
        $display("FAIL ovf_set: cyc %0d got %b, required %b", cyc, ovf_o, cyc >= f2);
      end
      if (cyc >= f1) begin
        n_checks++;
        if (evt_valid !== 1'b1 || evt_rise !== 1'b1 || evt_interval !== W'(sat(iv1, W))) begin
          n_fail++;
          $display("FAIL held_payload: cyc %0d got v=%b r=%b iv=%0d, required 1 1 %0d",
                   cyc, evt_valid, evt_rise, evt_interval, sat(iv1, W));
        end
      end
    end
    wait_until(k + 14);
    din = 1'b1;
    expect_edge(1'b1, 1'b0, f3, iv);
    wait_until(f3 - 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (ovf_o !== 1'b1 || evt_rise !== 1'b1 || evt_interval !== W'(sat(iv1, W))) begin
      n_fail++;
      $display("FAIL ovf_set_wins: got ovf=%b r=%b iv=%0d, required 1 1 %0d",
               ovf_o, evt_rise, evt_interval, sat(iv1, W));
    end
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    n_checks++;
    if (ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b, required 0", ovf_o);
    end
    evt_ready = 1'b1;
    tick();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_clears: got v=%b, required 0", evt_valid);
    end
  endtask

  task automatic test_back_to_back();
    int k, f1, f2;
    int unsigned iv1, iv2;
    evt_ready = 1'b0;
    k = cyc;
    din = 1'b0;
    expect_edge(1'b0, 1'b1, f1, iv1);
    wait_until(k + 4);
    din = 1'b1;
    expect_edge(1'b1, 1'b1, f2, iv2);
    wait_until(f2 - 1);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_rise !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got v=%b r=%b, required 1 0", evt_valid, evt_rise);
    end
    evt_ready = 1'b1;
    tick();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_rise !== 1'b1 || evt_interval !== W'(sat(iv2, W)) || ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_reload: got v=%b r=%b iv=%0d ovf=%b, required 1 1 %0d 0",
               evt_valid, evt_rise, evt_interval, ovf_o, sat(iv2, W));
    end
    tick();
    n_checks++;
    if (evt_valid !== 1'b0 || ovf_o !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got v=%b ovf=%b, required 0 0", evt_valid, ovf_o);
    end
  endtask

  task automatic test_reset_mid();
    int k, f;
    int unsigned iv;
    evt_ready = 1'b0;
    k = cyc;
    din = 1'b0;
    expect_edge(1'b0, 1'b0, f, iv);
    wait_until(f);
    n_checks++;
    if (evt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_before_reset: got v=%b, required 1", evt_valid);
    end
    wait_until(k + 7);
    din = 1'b1;
    wait_until(k + 11);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    last_ref = cyc + 1;
    n_checks++;
    if ({level_o, evt_valid, evt_rise, evt_interval, ovf_o} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got lvl=%b v=%b r=%b iv=%0d ovf=%b, required all 0",
               level_o, evt_valid, evt_rise, evt_interval, ovf_o);
    end
    f = cyc + LAT;
    exp_q.push_back('{rise: 1'b1, iv: f - last_ref});
    last_ref = f;
    evt_ready = 1'b1;
    while (cyc < f + 2) begin
      tick();
      n_checks++;
      if (level_o !== (cyc >= f)) begin
        n_fail++;
        $display("FAIL requalify: cyc %0d got lvl=%b, required %b", cyc, level_o, cyc >= f);
      end
    end
  endtask

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_single_rise();
    test_glitch_filter();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    repeat (4) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL events_missing: got %0d unconsumed, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
